// File: rtl/aes_key_sched_ctrl.sv
// rtl/aes_key_sched_ctrl.sv - KeyExpansion sequencer streaming 128-bit round keys over valid/ready
module aes_key_sched_ctrl #(
    parameter int EXP_TIMEOUT = 80
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [255:0]   key,
    input  logic [7:0]     Nk,
    input  logic           ke_done,
    input  logic [1919:0]  ke_w,
    output logic           ke_reset,
    output logic [255:0]   ke_key,
    output logic [7:0]     ke_Nk,
    output logic [127:0]   rk,
    output logic [3:0]     rk_idx,
    output logic           rk_valid,
    input  logic           rk_ready,
    output logic           busy,
    output logic           done,
    output logic           err
);

    localparam int WDW = $clog2(EXP_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_EXPAND,
        S_ISSUE,
        S_DONE
    } state_t;

    state_t          state_q;
    logic            ke_reset_q;
    logic [255:0]    ke_key_q;
    logic [7:0]      ke_nk_q;
    logic [3:0]      rk_idx_q;
    logic            rk_valid_q;
    logic            busy_q;
    logic            done_q;
    logic            err_q;
    logic [WDW-1:0]  wdog_q;

    logic            nk_legal;
    logic [3:0]      nr;
    logic            last_rk;
    logic [10:0]     rk_base;

    assign nk_legal = (Nk == 8'd4) || (Nk == 8'd6) || (Nk == 8'd8);
    assign nr       = ke_nk_q[3:0] + 4'd6;
    assign last_rk  = (rk_idx_q == nr);

    // Round key i occupies words 4i..4i+3, counted from the MSB end of ke_w
    assign rk_base  = 11'd1919 - {rk_idx_q, 7'd0};
    assign rk       = ke_w[rk_base -: 128];

    assign ke_reset = ke_reset_q;
    assign ke_key   = ke_key_q;
    assign ke_Nk    = ke_nk_q;
    assign rk_idx   = rk_idx_q;
    assign rk_valid = rk_valid_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            ke_reset_q <= 1'b1;
            ke_key_q   <= '0;
            ke_nk_q    <= '0;
            rk_idx_q   <= '0;
            rk_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            wdog_q     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (nk_legal) begin
                            ke_key_q <= key;
                            ke_nk_q  <= Nk;
                            err_q    <= 1'b0;
                            busy_q   <= 1'b1;
                            state_q  <= S_LOAD;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    ke_reset_q <= 1'b0;
                    wdog_q     <= '0;
                    state_q    <= S_EXPAND;
                end
                S_EXPAND: begin
                    // A late doneFlag still wins over the watchdog in the same cycle
                    if (ke_done) begin
                        rk_idx_q   <= '0;
                        rk_valid_q <= 1'b1;
                        state_q    <= S_ISSUE;
                    end else if (wdog_q == WDW'(EXP_TIMEOUT - 1)) begin
                        err_q      <= 1'b1;
                        busy_q     <= 1'b0;
                        ke_reset_q <= 1'b1;
                        state_q    <= S_IDLE;
                    end else begin
                        wdog_q <= wdog_q + WDW'(1);
                    end
                end
                S_ISSUE: begin
                    if (rk_ready) begin
                        if (last_rk) begin
                            rk_valid_q <= 1'b0;
                            done_q     <= 1'b1;
                            state_q    <= S_DONE;
                        end else begin
                            rk_idx_q <= rk_idx_q + 4'd1;
                        end
                    end
                end
                S_DONE: begin
                    busy_q     <= 1'b0;
                    ke_reset_q <= 1'b1;
                    rk_idx_q   <= '0;
                    state_q    <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// tb/tb_aes_key_sched_ctrl.sv - scoreboard bench for aes_key_sched_ctrl with a behavioural KeyExpansion
module tb_aes_key_sched_ctrl;

    localparam int EXP_TIMEOUT = 80;

    logic           clk = 1'b0;
    logic           reset, start, ke_done, rk_ready;
    logic [255:0]   key;
    logic [7:0]     Nk;
    logic [1919:0]  ke_w;
    logic           ke_reset;
    logic [255:0]   ke_key;
    logic [7:0]     ke_Nk;
    logic [127:0]   rk;
    logic [3:0]     rk_idx;
    logic           rk_valid, busy, done, err;

    always #5 clk = ~clk;

    aes_key_sched_ctrl #(.EXP_TIMEOUT(EXP_TIMEOUT)) dut (
        .clk(clk), .reset(reset), .start(start), .key(key), .Nk(Nk),
        .ke_done(ke_done), .ke_w(ke_w), .ke_reset(ke_reset), .ke_key(ke_key),
        .ke_Nk(ke_Nk), .rk(rk), .rk_idx(rk_idx), .rk_valid(rk_valid),
        .rk_ready(rk_ready), .busy(busy), .done(done), .err(err)
    );

    int checks = 0;
    int failures = 0;
    int n_hs, n_done;
    logic [7:0]   sbox [256];
    logic [127:0] exp_rk_q [$];
    logic [3:0]   exp_idx_q [$];
    logic [127:0] got_rk [16];

    localparam logic [255:0] KEY4 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] KEY6 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] KEY8 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    task automatic build_sbox();
        logic [7:0] p, q, x;
        logic hi;
        p = 8'd1;
        q = 8'd1;
        do begin
            hi = p[7];
            p = p ^ (p << 1) ^ (hi ? 8'h1b : 8'h00);
            q = q ^ (q << 1);
            q = q ^ (q << 2);
            q = q ^ (q << 4);
            if (q[7]) q = q ^ 8'h09;
            x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
            sbox[p] = x ^ 8'h63;
        end while (p != 8'd1);
        sbox[0] = 8'h63;
    endtask

    function automatic logic [31:0] subw(input logic [31:0] v);
        return {sbox[v[31:24]], sbox[v[23:16]], sbox[v[15:8]], sbox[v[7:0]]};
    endfunction

    function automatic logic [1919:0] expand(input logic [255:0] k, input int nk);
        logic [31:0]   w [60];
        logic [31:0]   t;
        logic [7:0]    rc;
        logic [1919:0] r;
        int total;
        total = 4 * (nk + 7);
        rc = 8'h01;
        r = '0;
        for (int i = 0; i < 60; i++) w[i] = '0;
        for (int i = 0; i < total; i++) begin
            if (i < nk) begin
                w[i] = k[255-32*i -: 32];
            end else begin
                t = w[i-1];
                if (i % nk == 0) begin
                    t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                    rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
                end else if (nk > 6 && i % nk == 4) begin
                    t = subw(t);
                end
                w[i] = w[i-nk] ^ t;
            end
            r[1919-32*i -: 32] = w[i];
        end
        return r;
    endfunction

    task automatic run_sched(input logic [255:0] k, input int nk, input bit stall_pat, input int abort_at);
        logic [1919:0] w;
        logic [127:0]  stall_rk, er;
        logic [3:0]    stall_idx, ei;
        bit expect_done, stall_pend, fin;
        int nr, t;
        nr = nk + 6;
        w = expand(k, nk);
        exp_rk_q.delete();
        exp_idx_q.delete();
        for (int i = 0; i < 16; i++) got_rk[i] = '0;
        for (int i = 0; i <= nr; i++) begin
            exp_rk_q.push_back(w[1919-128*i -: 128]);
            exp_idx_q.push_back(4'(i));
        end
        n_hs = 0;
        n_done = 0;
        rk_ready = 1'b0;
        start = 1'b1;
        key = k;
        Nk = 8'(nk);
        cyc();
        start = 1'b0;
        chk("load_busy", busy, 1);
        chk("load_ke_reset", ke_reset, 1);
        chk("load_ke_key", ke_key, k);
        chk("load_ke_nk", ke_Nk, nk);
        chk("start_clears_err", err, 0);
        cyc();
        chk("expand_ke_reset", ke_reset, 0);
        repeat (6) cyc();
        ke_w = w;
        ke_done = 1'b1;
        @(negedge clk);
        chk("valid_before_done_seen", rk_valid, 0);
        cyc();
        chk("valid_rise", rk_valid, 1);
        chk("first_idx", rk_idx, 0);
        t = 0;
        fin = 0;
        expect_done = 0;
        stall_pend = 0;
        while (!fin && t < 200) begin
            rk_ready = stall_pat ? ((t % 4 == 0) || (t % 4 == 3)) : 1'b1;
            @(negedge clk);
            if (done) n_done++;
            if (expect_done) begin
                chk("done_after_last", done, 1);
                expect_done = 0;
            end
            if (stall_pend) begin
                chk("stall_rk_held", rk, stall_rk);
                chk("stall_idx_held", rk_idx, stall_idx);
                stall_pend = 0;
            end
            if (abort_at >= 0 && rk_valid && rk_idx == 4'(abort_at)) begin
                reset = 1'b1;
                cyc();
                chk("abort_rk_valid", rk_valid, 0);
                chk("abort_busy", busy, 0);
                chk("abort_ke_reset", ke_reset, 1);
                chk("abort_rk_idx", rk_idx, 0);
                chk("abort_done", done, 0);
                reset = 1'b0;
                fin = 1;
            end else if (rk_valid && rk_ready) begin
                n_hs++;
                if (exp_idx_q.size() == 0) begin
                    chk("extra_handshake", n_hs, nr + 1);
                end else begin
                    er = exp_rk_q.pop_front();
                    ei = exp_idx_q.pop_front();
                    chk("rk", rk, er);
                    chk("rk_idx", rk_idx, ei);
                    got_rk[rk_idx] = rk;
                    if (ei == 4'(nr)) expect_done = 1;
                end
            end else if (rk_valid) begin
                stall_pend = 1;
                stall_rk = rk;
                stall_idx = rk_idx;
            end else if (!busy && n_hs > 0) begin
                fin = 1;
            end
            @(posedge clk);
            #1;
            t++;
        end
        chk("sched_finished", fin, 1);
        ke_done = 1'b0;
        ke_w = '0;
        rk_ready = 1'b0;
        if (abort_at < 0) begin
            chk("handshake_count", n_hs, nr + 1);
            chk("done_pulses", n_done, 1);
            chk("err_clear", err, 0);
        end
    endtask

    initial begin
        build_sbox();
        reset = 1'b1;
        start = 1'b0;
        ke_done = 1'b0;
        ke_w = '0;
        rk_ready = 1'b0;
        key = '0;
        Nk = '0;
        repeat (3) cyc();
        reset = 1'b0;
        cyc();
        chk("rst_ke_reset", ke_reset, 1);
        chk("rst_ke_key", ke_key, 0);
        chk("rst_ke_nk", ke_Nk, 0);
        chk("rst_rk_idx", rk_idx, 0);
        chk("rst_rk_valid", rk_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);

        run_sched(KEY4, 4, 1'b0, -1);
        chk("nk4_round0", got_rk[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);
        chk("nk4_round10", got_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        run_sched(KEY6, 6, 1'b0, -1);
        chk("nk6_round0", got_rk[0], 128'h8e73b0f7da0e6452c810f32b809079e5);
        chk("nk6_round1", got_rk[1], 128'h62f8ead2522c6b7bfe0c91f72402f5a5);

        run_sched(KEY8, 8, 1'b1, -1);
        chk("nk8_round1", got_rk[1], 128'h1f352c073b6108d72d9810a30914dff4);

        // expansion that never finishes
        n_done = 0;
        start = 1'b1;
        key = KEY4;
        Nk = 8'd4;
        cyc();
        start = 1'b0;
        cyc();
        repeat (EXP_TIMEOUT - 1) begin
            cyc();
            if (done) n_done++;
        end
        chk("to_still_busy", busy, 1);
        chk("to_err_early", err, 0);
        cyc();
        chk("to_busy", busy, 0);
        chk("to_err", err, 1);
        chk("to_ke_reset", ke_reset, 1);
        chk("to_no_done", n_done, 0);

        // illegal key length
        start = 1'b1;
        key = KEY8;
        Nk = 8'd5;
        cyc();
        start = 1'b0;
        chk("bad_nk_err", err, 1);
        chk("bad_nk_busy", busy, 0);
        chk("bad_nk_ke_reset", ke_reset, 1);
        chk("bad_nk_keep_nk", ke_Nk, 4);
        chk("bad_nk_keep_key", ke_key, KEY4);
        cyc();
        chk("bad_nk_busy_later", busy, 0);

        run_sched(KEY4, 4, 1'b0, -1);
        run_sched(KEY4, 4, 1'b0, 5);
        run_sched(KEY4, 4, 1'b0, -1);
        chk("after_abort_round10", got_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
